// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path (and the future transmitter).
//   uart_state_e  : receiver FSM state encoding
//   baud_cnt_max  : sys_clk cycles per serial bit for a given clock and baud
//   DATA_BITS     : payload bits per frame
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int baud_cnt_max(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser plus one history flop for falling-edge detection.
// All flops reset to 1 so an idle-high line shows no edge out of reset.
//   sys_clk, sys_rst_n : clock, async active-low reset
//   async_in           : raw asynchronous input
//   sync_out           : synchronised level
//   fall_out           : one-cycle pulse on a 1->0 transition of sync_out
module rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall_out
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall_out = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver. Samples each bit at the middle of its bit period,
// presents the byte with a one-cycle po_flag, or a one-cycle po_err when the
// stop bit is low (po_data then keeps its previous value).
//   sys_clk, sys_rst_n : clock, async active-low reset
//   rx                 : asynchronous serial input, idle high
//   po_data            : last good byte
//   po_flag            : strobe, po_data just updated
//   po_err             : strobe, frame error
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       po_err
);

  localparam int BAUD_CNT_MAX = baud_cnt_max(CLK_FREQ, BAUD);
  localparam int CW           = ($clog2(BAUD_CNT_MAX) > 0) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [CW-1:0] CNT_MID  = CW'(BAUD_CNT_MAX / 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);

  logic rx_s, fall;

  rx_sync u_rx_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .async_in (rx),
    .sync_out (rx_s),
    .fall_out (fall)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        baud_cnt_q, baud_cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           po_data_q, po_data_d;
  logic                 po_flag_q, po_flag_d;
  logic                 po_err_q, po_err_d;
  logic                 mid;

  assign mid = (baud_cnt_q == CNT_MID);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    po_data_d = po_data_q;
    po_flag_d = 1'b0;
    po_err_d  = 1'b0;

    unique case (state_q)
      IDLE: if (fall) state_d = START;
      START: if (mid) begin
        // a start bit already high again at its middle was a glitch
        if (!rx_s) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: if (mid) begin
        shreg_d[bit_idx_q] = rx_s;
        bit_idx_d          = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (mid) begin
        // back to IDLE mid-stop so a directly following start edge is seen
        if (rx_s) begin
          po_data_d = shreg_q;
          po_flag_d = 1'b1;
        end else begin
          po_err_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // counter idles at 0, restarts from 0 on the accepted edge, else free-runs
    if (state_q == IDLE || state_d == IDLE) baud_cnt_d = '0;
    else if (baud_cnt_q == CNT_LAST)        baud_cnt_d = '0;
    else                                    baud_cnt_d = baud_cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      po_data_q  <= '0;
      po_flag_q  <= 1'b0;
      po_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      po_data_q  <= po_data_d;
      po_flag_q  <= po_flag_d;
      po_err_q   <= po_err_d;
    end
  end

  assign po_data = po_data_q;
  assign po_flag = po_flag_q;
  assign po_err  = po_err_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte. The bit period is shortened to 16 clocks
// so the whole run, including a 256-frame back-to-back stream, stays short.
// Expected events are derived from what is put on the line: a frame with a
// high stop bit yields its byte, a low stop bit (or a break) yields one error
// with po_data unchanged.
module tb_uart_rx_byte;
  import uart_pkg::*;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;
  localparam int BIT      = CLK_FREQ / BAUD;

  typedef struct {
    bit       is_err;
    bit [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag, po_err;

  ev_t      sb_q[$];
  bit [7:0] last_good = 8'h00;
  int       n_cmp = 0;
  int       n_bad = 0;

  always #5 clk = ~clk;

  uart_rx_byte #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .po_err   (po_err)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bit_time(input logic v, input int cycles);
    rx = v;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic idle(input int cycles);
    bit_time(1'b1, cycles);
  endtask

  task automatic send_frame(input bit [7:0] b, input bit stop_ok);
    ev_t e;
    e.is_err = !stop_ok;
    if (stop_ok) last_good = b;
    e.data = last_good;
    sb_q.push_back(e);
    bit_time(1'b0, BIT);
    for (int j = 0; j < 8; j++) bit_time(b[j], BIT);
    bit_time(stop_ok, BIT);
    // a low stop bit must be followed by idle before the next start edge
    if (!stop_ok) idle(2);
  endtask

  // monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (po_flag || po_err) begin
      chk("flag_err_exclusive", int'(po_flag && po_err), 0);
      if (sb_q.size() == 0) begin
        chk("unexpected_strobe", {po_err, po_flag, po_data}, 0);
      end else begin
        ev_t e;
        e = sb_q.pop_front();
        chk("strobe_kind", int'(po_err), int'(e.is_err));
        chk("po_data", int'(po_data), int'(e.data));
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    chk("reset_po_data", int'(po_data), 0);
    chk("reset_po_flag", int'(po_flag), 0);
    chk("reset_po_err",  int'(po_err), 0);
    rst_n = 1'b1;
    idle(2 * BIT);

    // two frames with an idle gap
    send_frame(8'h55, 1'b1);
    idle(3 * BIT);
    send_frame(8'hA3, 1'b1);
    idle(2 * BIT);

    // short low glitch well under half a bit: rejected silently
    bit_time(1'b0, 5);
    idle(BIT);
    chk("glitch_idle", int'(dut.state_q), int'(IDLE));
    idle(BIT);

    // framing error after a good byte
    send_frame(8'h55, 1'b1);
    idle(BIT);
    send_frame(8'h3C, 1'b0);
    idle(2 * BIT);

    // random bytes, random stop validity, random gaps
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), $urandom_range(0, 3) != 0);
      idle($urandom_range(0, 2 * BIT));
    end
    idle(2 * BIT);

    // back-to-back stream, no idle between frames
    for (int i = 0; i < 256; i++) send_frame(8'(i % 256), 1'b1);
    idle(2 * BIT);

    // reset in the middle of data bit 4 of 0xFF
    bit_time(1'b0, BIT);
    for (int j = 0; j < 4; j++) bit_time(1'b1, BIT);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_po_data", int'(po_data), 0);
    chk("midreset_po_flag", int'(po_flag), 0);
    chk("midreset_po_err",  int'(po_err), 0);
    last_good = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    idle(2 * BIT);
    send_frame(8'h0F, 1'b1);
    idle(2 * BIT);

    // break: three frame-times low gives a single error
    begin
      ev_t e;
      e.is_err = 1'b1;
      e.data   = last_good;
      sb_q.push_back(e);
    end
    bit_time(1'b0, 30 * BIT);
    idle(2 * BIT);
    send_frame(8'h81, 1'b1);
    idle(3 * BIT);

    chk("events_outstanding", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
